// File: rtl/mac_accumulator_if.sv
// Handshake bundle for mac_accumulator.
//   in_valid/in_ready/in_m/in_q : operand-pair input stream
//   out_valid/out_ready/out_sum/out_ovf : dot-product result stream
// slave  : view seen by mac_accumulator
// master : view seen by the producer/consumer (testbench or upstream logic)
interface mac_accumulator_if #(
  parameter int unsigned ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_m;
  logic [3:0]       in_q;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_m, in_q, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_m, in_q, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Sequencing/accumulation stage around a 4x4 combinational array multiplier.
// Operand pairs are accepted over bus.in_*, registered onto mul_m/mul_q, and the
// returned product mul_p is summed one cycle later. After N_TERMS products the
// result is presented on bus.out_* until the downstream handshake.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : operand input and result output handshakes (slave view)
//   mul_m, mul_q : registered operands to the array multiplier
//   mul_p        : combinational product back from the array multiplier
//   busy         : batch in progress or result pending
module mac_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_accumulator_if.slave     bus,
  output logic [3:0]           mul_m,
  output logic [3:0]           mul_q,
  input  logic [7:0]           mul_p,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             pend;
  logic             ovf;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_ovf_r;
  logic [ACC_W:0]   sum;
  logic             accept;

  assign accept = bus.in_valid && (state == ACCUM);
  // One extra bit so the carry out of ACC_W feeds the sticky overflow flag.
  assign sum    = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, mul_p};

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;
  assign busy          = (state != ACCUM) || (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (accept && (cnt == LAST_CNT)) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      ovf       <= 1'b0;
      mul_m     <= '0;
      mul_q     <= '0;
      out_sum_r <= '0;
      out_ovf_r <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            mul_m <= bus.in_m;
            mul_q <= bus.in_q;
            cnt   <= cnt + 8'd1;
            pend  <= 1'b1;
          end else begin
            pend  <= 1'b0;
          end
          if (pend) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
          end
        end
        DRAIN: begin
          // The last accepted product is still pending here; fold it straight
          // into the result registers.
          out_sum_r <= sum[ACC_W-1:0];
          out_ovf_r <= ovf | sum[ACC_W];
          pend      <= 1'b0;
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_m;
  logic [3:0] in_q;
  logic       out_ready;

  logic [3:0] mul_m12, mul_q12, mul_m9, mul_q9;
  logic [7:0] mul_p12, mul_p9;
  logic       busy12, busy9;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;
  int unsigned last_acc_cyc;

  mac_accumulator_if #(.ACC_W(12)) bus12 ();
  mac_accumulator_if #(.ACC_W(9))  bus9  ();

  assign bus12.in_valid  = in_valid;
  assign bus12.in_m      = in_m;
  assign bus12.in_q      = in_q;
  assign bus12.out_ready = out_ready;
  assign bus9.in_valid   = in_valid;
  assign bus9.in_m       = in_m;
  assign bus9.in_q       = in_q;
  assign bus9.out_ready  = out_ready;

  // Stand-in for the array multiplier.
  assign mul_p12 = 8'(mul_m12 * mul_q12);
  assign mul_p9  = 8'(mul_m9 * mul_q9);

  mac_accumulator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12),
    .mul_m (mul_m12),
    .mul_q (mul_q12),
    .mul_p (mul_p12),
    .busy  (busy12)
  );

  mac_accumulator #(.N_TERMS(4), .ACC_W(9)) u_dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9),
    .mul_m (mul_m9),
    .mul_q (mul_q9),
    .mul_p (mul_p9),
    .busy  (busy9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair and steps until it is accepted; in_valid is left high.
  task automatic send(input logic [3:0] m, input logic [3:0] q);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_m     = m;
    in_q     = q;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus12.in_ready) done = 1;
      tick();
    end
    if (done) last_acc_cyc = cyc;
    else check("send_timeout", 0, 1);
  endtask

  initial begin
    int unsigned first1;
    int unsigned first2;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_m      = '0;
    in_q      = '0;
    out_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out_sum",   bus12.out_sum,   0);
    check("rst_out_ovf",   bus12.out_ovf,   0);
    check("rst_out_valid", bus12.out_valid, 0);
    check("rst_in_ready",  bus12.in_ready,  1);
    check("rst_busy",      busy12,          0);
    check("rst_mul_m",     mul_m12,         0);
    check("rst_mul_q",     mul_q12,         0);
    tick();
    check("idle_mul_m",    mul_m12,         0);

    // 2: back-to-back batch
    out_ready = 1'b1;
    send(3, 5);
    send(15, 15);
    send(0, 9);
    send(7, 2);
    in_valid = 1'b0;
    check("t2_drain_valid", bus12.out_valid, 0);
    check("t2_drain_ready", bus12.in_ready,  0);
    check("t2_drain_busy",  busy12,          1);
    check("t2_mul_m",       mul_m12,         7);
    check("t2_mul_q",       mul_q12,         2);
    tick();
    check("t2_valid",       bus12.out_valid, 1);
    check("t2_sum",         bus12.out_sum,   254);
    check("t2_ovf",         bus12.out_ovf,   0);
    tick();
    check("t2_valid_drop",  bus12.out_valid, 0);
    check("t2_ready_back",  bus12.in_ready,  1);
    check("t2_busy_idle",   busy12,          0);

    // 3: bubbles and downstream back-pressure
    out_ready = 1'b0;
    send(3, 5);   in_valid = 1'b0; tick(); tick();
    check("t3_bubble_busy", busy12,  1);
    check("t3_bubble_mulm", mul_m12, 3);
    send(15, 15); in_valid = 1'b0; tick(); tick();
    send(0, 9);   in_valid = 1'b0; tick(); tick();
    send(7, 2);   in_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", bus12.out_valid, 1);
      check("t3_hold_sum",   bus12.out_sum,   254);
      check("t3_hold_ready", bus12.in_ready,  0);
      tick();
    end
    check("t3_hs_valid", bus12.out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("t3_after_valid", bus12.out_valid, 0);
    check("t3_after_ready", bus12.in_ready,  1);

    // 4: overflow on the 9-bit instance, then clean batch
    for (int i = 0; i < 4; i++) send(15, 15);
    in_valid = 1'b0;
    tick();
    check("t4_sum9",  bus9.out_sum,  388);
    check("t4_ovf9",  bus9.out_ovf,  1);
    check("t4_sum12", bus12.out_sum, 900);
    check("t4_ovf12", bus12.out_ovf, 0);
    tick();
    for (int i = 0; i < 4; i++) send(1, 1);
    in_valid = 1'b0;
    tick();
    check("t4b_sum9", bus9.out_sum, 4);
    check("t4b_ovf9", bus9.out_ovf, 0);
    tick();

    // 5: reset aborts a partial batch
    send(15, 15);
    send(15, 15);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_busy",  busy12,          0);
    check("t5_valid", bus12.out_valid, 0);
    check("t5_mul_m", mul_m12,         0);
    for (int i = 0; i < 4; i++) send(1, 1);
    in_valid = 1'b0;
    tick();
    check("t5_valid_res", bus12.out_valid, 1);
    check("t5_sum",       bus12.out_sum,   4);
    check("t5_ovf",       bus12.out_ovf,   0);
    tick();

    // 6: continuous streaming over two batches
    send(2, 3);
    first1 = last_acc_cyc;
    for (int i = 0; i < 3; i++) send(2, 3);
    tick();
    check("t6_valid1", bus12.out_valid, 1);
    check("t6_sum1",   bus12.out_sum,   24);
    send(4, 4);
    first2 = last_acc_cyc;
    check("t6_period", first2 - first1, 6);
    for (int i = 0; i < 3; i++) send(4, 4);
    in_valid = 1'b0;
    tick();
    check("t6_sum2", bus12.out_sum, 64);
    check("t6_ovf2", bus12.out_ovf, 0);
    tick();
    check("t6_done_valid", bus12.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Sequencing and accumulation stage wrapped around the 4x4 combinational array multiplier. It accepts 4-bit operand pairs over a valid/ready handshake and drives each pair to the multiplier from registers. It captures the 8-bit product one cycle later and sums N_TERMS products into a dot-product result, which it presents downstream over a second valid/ready handshake.

Parameters:
N_TERMS, 4, products per result; legal range 1..255.
ACC_W, 12, accumulator/result width; legal range 8..16. Results wrap modulo 2^ACC_W; an overflow is flagged.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
in_valid  input  1  operand pair on in_m/in_q is valid.
in_ready  output  1  block can accept an operand pair this cycle.
in_m  input  4  multiplicand.
in_q  input  4  multiplier.
mul_m  output  4  registered multiplicand to the array multiplier.
mul_q  output  4  registered multiplier to the array multiplier.
mul_p  input  8  combinational product returned by the array multiplier.
out_valid  output  1  out_sum/out_ovf hold a completed result.
out_ready  input  1  downstream accepts the result.
out_sum  output  ACC_W  accumulated sum of N_TERMS products.
out_ovf  output  1  sticky: at least one accumulation carried out of ACC_W bits.
busy  output  1  high when state is not ACCUM or at least one pair is accepted in the current batch.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM; acc, cnt and pend are cleared.
  - Outputs: mul_m=0, mul_q=0, out_sum=0, out_ovf=0, out_valid=0, busy=0.
  - Any partial batch or held result is discarded; no output handshake occurs.
- in_ready = (state==ACCUM), decoded from registered state only. It does not depend combinationally on in_valid.
- Accept event: in_valid && in_ready at a clk edge.
- State ACCUM:
  - On accept: mul_m<=in_m, mul_q<=in_q, pend<=1, cnt<=cnt+1.
  - Without accept: pend<=0. mul_m/mul_q hold their last values.
  - If pend==1 in a cycle, the sum acc+{0,mul_p} is computed in ACC_W+1 bits. acc<=sum[ACC_W-1:0]; ovf<=ovf|sum[ACC_W].
  - On the accept that makes cnt==N_TERMS, next state is DRAIN.
- State DRAIN (one cycle):
  - Adds the last product: out_sum<=final wrapped sum, out_ovf<=final sticky flag, out_valid<=1.
  - pend<=0; next state HOLD.
- State HOLD:
  - out_valid=1; out_sum and out_ovf are held stable. in_ready=0.
  - On out_valid && out_ready: out_valid<=0, acc<=0, cnt<=0, ovf<=0, next state ACCUM.
  - in_ready=1 on the following cycle. No accept can coincide with the output handshake.
- Timing:
  - Operand accepted at edge k → product valid on mul_p during cycle k+1 → accumulated at edge k+1.
  - out_valid rises at the edge one cycle after the Nth accept.
  - Minimum batch period is N_TERMS+2 cycles with continuous in_valid and out_ready.
- Bubbles (in_valid=0) in ACCUM leave acc and cnt unchanged.
- N_TERMS=1: ACCUM → DRAIN directly after the first accept.
- Products are unsigned, zero-extended to ACC_W before the add.
- out_ovf clears only on the output handshake or on reset.

Test Plan:
1. Hold rst_n=0 for 2 edges, then release → all outputs 0, in_ready=1, busy=0; mul_m/mul_q stay 0 until the first accept.
2. Defaults; back-to-back pairs (3,5),(15,15),(0,9),(7,2) with out_ready=1 → out_sum=254, out_ovf=0. out_valid rises exactly 1 cycle after the 4th accept edge and stays high for 1 cycle.
3. Same pairs with 2-cycle in_valid bubbles between them, and out_ready held low for 5 cycles after out_valid → out_sum=254 held stable, in_ready=0 throughout HOLD. Handshake on the 6th cycle; in_ready=1 on the next cycle.
4. ACC_W=9; four pairs of (15,15) → out_sum=388 (900 mod 512), out_ovf=1. The next batch of (1,1)x4 gives out_sum=4, out_ovf=0.
5. Accept 2 pairs (15,15), then assert rst_n=0 for 1 edge; then send (1,1)x4 → no result from the aborted batch, out_sum=4, out_ovf=0.
6. Continuous in_valid=1 and out_ready=1 over two batches: (2,3)x4 then (4,4)x4 → out_sum=24, then 64. Accumulator is cleared between batches; batch period is 6 cycles.
